ahfp_addsub_pipe: RTL
=====================

# ahfp_addsub_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor. It is the next generation of the team's fixed-width single-precision subtractor, adding:

- run-time add/sub mode;
- configurable exponent and mantissa widths;
- round-to-nearest-even;
- IEEE special-value handling and exception flags;
- a valid/stall pipeline.

It sits in the datapath alongside the other ahfp arithmetic units and accepts one operation per cycle.

## Interface
- EXP_W, 8, exponent width (≥ 4)
- MAN_W, 23, stored mantissa width, excluding the hidden bit (≥ 4)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  pipeline advance; when 0, every stage register holds
- in_valid  input  1  operands valid this cycle
- op  input  1  0 = dataa + datab, 1 = dataa − datab
- dataa, datab  input  1+EXP_W+MAN_W  operands: sign, exponent, mantissa
- out_valid  output  1  result valid
- result  output  1+EXP_W+MAN_W  rounded result
- flag_ovf, flag_unf, flag_inv  output  1 each  overflow, underflow, invalid; valid only with out_valid

## Operation
- **Input handling**
  - Exponent 0 is treated as zero (denormals flushed to zero, sign kept).
  - All-ones exponent with zero mantissa is ±inf; with a nonzero mantissa it is NaN.
  - op=1 inverts datab's sign before processing.
- **S1 – unpack and order**
  - Unpack, classify, and attach the hidden bit.
  - Swap so that operand A has the larger magnitude, comparing exponent then mantissa.
  - The effective operation is subtract when the signs differ.
- **S2 – align**
  - Shift B right by (eA − eB) into a MAN_W+4-bit field: significand plus guard, round and sticky bits.
  - The shift saturates at MAN_W+3.
  - All bits shifted out are ORed into sticky.
- **S3 – add/subtract**
  - Add or subtract in a MAN_W+5-bit field (adds a carry bit).
  - Subtraction never goes negative because of the S1 ordering.
- **S4 – normalise**
  - The leading-zero count drives normalisation.
  - On carry-out: shift right 1 (keeping sticky) and increment the exponent.
  - Otherwise: shift left by the leading-zero count and subtract it from the exponent.
  - A zero sum gives an exact zero.
- **S5 – round and pack**
  - Round to nearest even using guard, round and sticky.
  - A rounding carry renormalises and increments the exponent.
  - Pack the result and set flags.
- **Exact zero sign**
  - +0, except −0 when both effective operands are −0.
- **Overflow**
  - Final exponent ≥ 2^EXP_W − 1 produces ±inf and sets flag_ovf.
- **Underflow**
  - Final exponent ≤ 0 produces ±0 and sets flag_unf.
- **Special values**
  - Any NaN input produces the canonical quiet NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0) and sets flag_inv.
  - inf − inf (effective) produces the canonical NaN and sets flag_inv.
  - inf ± finite produces that inf.
  - Specials bypass the arithmetic path but travel through the pipeline with identical latency.

## Timing
- **Latency:** exactly 5 enabled cycles. in_valid=1 sampled with en=1 at edge k gives out_valid=1 after edge k+5, provided en=1 throughout.
- **Throughput:** one operation per enabled cycle; back-to-back operations are allowed.
- **en=0:**
  - All stage registers hold, including out_valid, result and flags.
  - Inputs are ignored (not sampled).
  - Order and values are preserved on resume.
- **Invalid cycles:** in_valid=0 slots propagate as bubbles with out_valid=0. result and flags then hold their last valid values.
- **Reset values:** out_valid, result and all flags are 0; all stage valid bits are 0.
- **Reset mid-operation:** in-flight operations are discarded and no out_valid pulse follows.
- **Simultaneous reset and en:** reset dominates.

## Structure
- **Package ahfp_pkg:**
  - functions for the field widths (significand, working field), the canonical-NaN constant and the inf constant, all parametrised by EXP_W/MAN_W;
  - the operand-class enum {ZERO, NORM, INF, NAN}.
- **Sub-module ahfp_lzd_param:** parametrised leading-zero detector with input width W, count output of width $clog2(W+1), and a valid-when-nonzero output. It replaces the fixed 48-bit detector and is used in S4.
- Each stage is a registered block carrying a valid bit, sign, exponent, significand and class/flag bits.

## Test plan
- **Basic add:** 0x3FC00000 + 0x40100000, op=0 (1.5 + 2.25) -> 0x40700000 after 5 cycles, no flags.
- **Cancellation and zero sign:**
  - 0x3F800000 − 0x3F800000 -> 0x00000000.
  - 0x80000000 + 0x80000000 -> 0x80000000.
- **Rounding:**
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000.
  - 0x3F800000 + 0x34400000 -> 0x3F800002.
- **Specials:**
  - 0x7F800000 − 0x7F800000 -> 0x7FC00000 with flag_inv.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with flag_ovf.
  - NaN input -> 0x7FC00000 with flag_inv.
- **Stall and stream:**
  - Stream 8 random operations back-to-back, dropping en for 2 cycles mid-stream -> outputs in order, delayed by exactly 2 cycles, bit-exact to the reference model.
  - Assert reset mid-stream -> no out_valid until new inputs are applied plus 5 cycles.
- **Half precision:** EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000; 0x7BFF + 0x7BFF -> 0x7C00 with flag_ovf.

Source files
------------

// File: rtl/ahfp_pkg.sv
// Shared definitions for the ahfp arithmetic units: operand classes and
// width-parametrised field helpers and special-value constants.
package ahfp_pkg;

    localparam int MAX_W = 128;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} ahfp_cls_e;

    function automatic int sig_w(input int man_w);
        return man_w + 1;
    endfunction

    // Significand plus guard, round and sticky.
    function automatic int work_w(input int man_w);
        return man_w + 4;
    endfunction

    // Exponent all ones, mantissa zero, sign clear.
    function automatic logic [MAX_W-1:0] inf_bits(input int exp_w, input int man_w);
        return ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
    endfunction

    function automatic logic [MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
        return inf_bits(exp_w, man_w) | (MAX_W'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/ahfp_lzd_param.sv
// Parametrised leading-zero detector; count is W when the input is all zero.
module ahfp_lzd_param #(
    parameter int W = 48
) (
    input  logic [W-1:0]             din,
    output logic [$clog2(W+1)-1:0]   count,
    output logic                     valid
);
    localparam int CW = $clog2(W + 1);

    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) count = CW'(W - 1 - i);
        end
    end

    assign valid = |din;

endmodule

// File: rtl/ahfp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor: input register, then unpack/order,
// align, add, normalise and round/pack stages; specials ride the same pipe.
module ahfp_addsub_pipe
    import ahfp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   dataa,
    input  logic [EXP_W+MAN_W:0]   datab,
    output logic                   out_valid,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   flag_ovf,
    output logic                   flag_unf,
    output logic                   flag_inv
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = sig_w(MAN_W);
    localparam int WW = work_w(MAN_W);
    localparam int CW = $clog2(WW + 1);
    localparam int XW = EXP_W + CW + 2;
    localparam logic [31:0] SH_MAX = 32'(MAN_W + 3);
    localparam logic signed [XW-1:0] X_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] X_ZERO = '0;
    localparam logic [MAX_W-1:0] INF_FULL  = inf_bits(EXP_W, MAN_W);
    localparam logic [MAX_W-1:0] QNAN_FULL = qnan_bits(EXP_W, MAN_W);
    localparam logic [W-2:0] INF_MAG = INF_FULL[W-2:0];
    localparam logic [W-1:0] QNAN    = QNAN_FULL[W-1:0];

    // Handshake: a stage captures only when en=1; its valid bit copies the
    // previous stage's valid, so in_valid=0 slots travel as bubbles and en=0
    // freezes every stage. There is no other backpressure.

    function automatic ahfp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) return ZERO;
        if (e != '1) return NORM;
        return (m == '0) ? INF : NAN;
    endfunction

    // Input register
    logic         v0, op0;
    logic [W-1:0] a0, b0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0 <= 1'b0; op0 <= 1'b0; a0 <= '0; b0 <= '0;
        end else if (en) begin
            v0 <= in_valid; op0 <= op; a0 <= dataa; b0 <= datab;
        end
    end

    // S1: classify, order by magnitude, resolve specials
    ahfp_cls_e     cls_a, cls_b;
    logic          sa, sb, swap, spec_c, inv_c;
    logic [W-2:0]  key_a, key_b;
    logic [SW-1:0] sig_a, sig_b;
    logic [W-1:0]  sres_c;
    always_comb begin
        sa     = a0[W-1];
        sb     = b0[W-1] ^ op0;
        cls_a  = classify(a0[W-2:MAN_W], a0[MAN_W-1:0]);
        cls_b  = classify(b0[W-2:MAN_W], b0[MAN_W-1:0]);
        key_a  = (cls_a == ZERO) ? '0 : a0[W-2:0];
        key_b  = (cls_b == ZERO) ? '0 : b0[W-2:0];
        swap   = key_b > key_a;
        sig_a  = (cls_a == NORM) ? {1'b1, a0[MAN_W-1:0]} : '0;
        sig_b  = (cls_b == NORM) ? {1'b1, b0[MAN_W-1:0]} : '0;
        spec_c = 1'b1;
        inv_c  = 1'b0;
        sres_c = QNAN;
        if (cls_a == NAN || cls_b == NAN) begin
            inv_c = 1'b1;
        end else if (cls_a == INF && cls_b == INF) begin
            if (sa != sb) inv_c = 1'b1;
            else          sres_c = {sa, INF_MAG};
        end else if (cls_a == INF) begin
            sres_c = {sa, INF_MAG};
        end else if (cls_b == INF) begin
            sres_c = {sb, INF_MAG};
        end else begin
            spec_c = 1'b0;
        end
    end

    logic             v1, sub1, s1, zs1, spec1, inv1;
    logic [EXP_W-1:0] e1, eb1;
    logic [SW-1:0]    siga1, sigb1;
    logic [W-1:0]     sres1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0; sub1 <= 1'b0; s1 <= 1'b0; zs1 <= 1'b0; spec1 <= 1'b0; inv1 <= 1'b0;
            e1 <= '0; eb1 <= '0; siga1 <= '0; sigb1 <= '0; sres1 <= '0;
        end else if (en) begin
            v1    <= v0;
            sub1  <= sa ^ sb;
            s1    <= swap ? sb : sa;
            zs1   <= sa & sb;
            e1    <= swap ? b0[W-2:MAN_W] : a0[W-2:MAN_W];
            eb1   <= swap ? a0[W-2:MAN_W] : b0[W-2:MAN_W];
            siga1 <= swap ? sig_b : sig_a;
            sigb1 <= swap ? sig_a : sig_b;
            spec1 <= spec_c;
            inv1  <= inv_c;
            sres1 <= sres_c;
        end
    end

    // S2: align the smaller operand, folding shifted-out bits into sticky
    logic [EXP_W-1:0] diff;
    logic [31:0]      diff32;
    logic [CW-1:0]    sh;
    logic [WW-1:0]    fb_full, fb_shift;
    logic             lost;
    always_comb begin
        diff     = e1 - eb1;
        diff32   = 32'(diff);
        sh       = (diff32 > SH_MAX) ? SH_MAX[CW-1:0] : diff32[CW-1:0];
        fb_full  = {sigb1, 3'b000};
        fb_shift = fb_full >> sh;
        lost     = |(fb_full & ~({WW{1'b1}} << sh));
    end

    logic             v2, sub2, s2, zs2, spec2, inv2;
    logic [EXP_W-1:0] e2;
    logic [WW-1:0]    fa2, fb2;
    logic [W-1:0]     sres2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2 <= 1'b0; sub2 <= 1'b0; s2 <= 1'b0; zs2 <= 1'b0; spec2 <= 1'b0; inv2 <= 1'b0;
            e2 <= '0; fa2 <= '0; fb2 <= '0; sres2 <= '0;
        end else if (en) begin
            v2 <= v1; sub2 <= sub1; s2 <= s1; zs2 <= zs1; spec2 <= spec1; inv2 <= inv1;
            e2    <= e1;
            fa2   <= {siga1, 3'b000};
            fb2   <= fb_shift | WW'(lost);
            sres2 <= sres1;
        end
    end

    // S3: magnitude add/subtract; ordering keeps the difference non-negative
    logic             v3, s3, zs3, spec3, inv3;
    logic [EXP_W-1:0] e3;
    logic [WW:0]      sum3;
    logic [W-1:0]     sres3;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v3 <= 1'b0; s3 <= 1'b0; zs3 <= 1'b0; spec3 <= 1'b0; inv3 <= 1'b0;
            e3 <= '0; sum3 <= '0; sres3 <= '0;
        end else if (en) begin
            v3 <= v2; s3 <= s2; zs3 <= zs2; spec3 <= spec2; inv3 <= inv2;
            e3    <= e2;
            sum3  <= sub2 ? ({1'b0, fa2} - {1'b0, fb2}) : ({1'b0, fa2} + {1'b0, fb2});
            sres3 <= sres2;
        end
    end

    // S4: normalise
    logic [CW-1:0]          lz;
    logic                   nz;
    logic [WW-1:0]          norm_c;
    logic signed [XW-1:0]   x_c;

    ahfp_lzd_param #(.W(WW)) u_lzd (
        .din   (sum3[WW-1:0]),
        .count (lz),
        .valid (nz)
    );

    always_comb begin
        if (sum3[WW]) begin
            norm_c = {sum3[WW:2], sum3[1] | sum3[0]};
            x_c    = XW'(e3) + XW'(1);
        end else begin
            norm_c = sum3[WW-1:0] << lz;
            x_c    = XW'(e3) - XW'(lz);
        end
    end

    logic                 v4, s4, zs4, zero4, spec4, inv4;
    logic signed [XW-1:0] x4;
    logic [WW-1:0]        norm4;
    logic [W-1:0]         sres4;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v4 <= 1'b0; s4 <= 1'b0; zs4 <= 1'b0; zero4 <= 1'b0; spec4 <= 1'b0; inv4 <= 1'b0;
            x4 <= '0; norm4 <= '0; sres4 <= '0;
        end else if (en) begin
            v4 <= v3; s4 <= s3; zs4 <= zs3; spec4 <= spec3; inv4 <= inv3;
            zero4 <= !sum3[WW] && !nz;
            x4    <= x_c;
            norm4 <= norm_c;
            sres4 <= sres3;
        end
    end

    // S5: round to nearest even, then range-check and pack
    logic [SW-1:0]        sig5;
    logic                 rnd, ovf_c, unf_c;
    logic [SW:0]          rsum;
    logic [MAN_W-1:0]     man5;
    logic signed [XW-1:0] x5;
    logic [W-1:0]         res_c;
    always_comb begin
        sig5 = norm4[WW-1:3];
        rnd  = norm4[2] & (norm4[1] | norm4[0] | sig5[0]);
        rsum = {1'b0, sig5} + (SW+1)'(rnd);
        if (rsum[SW]) begin
            man5 = rsum[MAN_W:1];
            x5   = x4 + XW'(1);
        end else begin
            man5 = rsum[MAN_W-1:0];
            x5   = x4;
        end
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (spec4) begin
            res_c = sres4;
        end else if (zero4) begin
            res_c = {zs4, {(W-1){1'b0}}};
        end else if (x5 >= X_MAX) begin
            res_c = {s4, INF_MAG};
            ovf_c = 1'b1;
        end else if (x5 <= X_ZERO) begin
            res_c = {s4, {(W-1){1'b0}}};
            unf_c = 1'b1;
        end else begin
            res_c = {s4, x5[EXP_W-1:0], man5};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0; result <= '0;
            flag_ovf <= 1'b0; flag_unf <= 1'b0; flag_inv <= 1'b0;
        end else if (en) begin
            out_valid <= v4;
            if (v4) begin
                result   <= res_c;
                flag_ovf <= ovf_c;
                flag_unf <= unf_c;
                flag_inv <= spec4 & inv4;
            end
        end
    end

endmodule
